// File: rtl/cmvn_frame_sequencer.sv
// CMVN frame sequencer: walks every (frame, bin) element of a feature block.
// For each element it reads the raw feature, sends one request to the CMVN
// datapath, waits for the echoed result and writes it to the result buffer.
module cmvn_frame_sequencer #(
  parameter int unsigned NUM_BINS   = 20,
  parameter int unsigned NUM_FRAMES = 50,
  parameter int unsigned DW         = 32,
  parameter int unsigned AW         = 10,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic          abort_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic          fb_rd_en_o,
  output logic [AW-1:0] fb_rd_addr_o,
  input  logic [DW-1:0] fb_rd_data_i,
  output logic          dp_req_o,
  output logic [DW-1:0] dp_data_o,
  output logic [4:0]    dp_bin_o,
  input  logic          dp_res_valid_i,
  input  logic [4:0]    dp_res_bin_i,
  input  logic [DW-1:0] dp_res_data_i,
  output logic          res_wr_en_o,
  output logic [AW-1:0] res_wr_addr_o,
  output logic [DW-1:0] res_wr_data_o
);

  localparam int unsigned BW = 5;
  localparam int unsigned FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_WAIT_RD  = 3'd2,
    S_ISSUE    = 3'd3,
    S_WAIT_RES = 3'd4,
    S_WRITE    = 3'd5,
    S_DONE     = 3'd6
  } state_e;

  state_e state_q, state_d;

  logic [BW-1:0] bin_q, bin_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
  logic          valid_q;

  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          fb_rd_en_q, fb_rd_en_d;
  logic [AW-1:0] fb_addr_q, fb_addr_d;
  logic          dp_req_q, dp_req_d;
  logic [DW-1:0] dp_data_q, dp_data_d;
  logic [BW-1:0] dp_bin_q, dp_bin_d;
  logic          res_wr_en_q, res_wr_en_d;
  logic [AW-1:0] res_addr_q, res_addr_d;
  logic [DW-1:0] res_data_q, res_data_d;

  logic start_ok_c;
  logic accept_c;
  logic bin_bad_c;
  logic tmo_hit_c;
  logic last_elem_c;

  // Event decode: a held-high valid only counts on its rising edge.
  assign start_ok_c  = (state_q == S_IDLE) && start_i && !abort_i;
  assign accept_c    = (state_q == S_WAIT_RES) && dp_res_valid_i && !valid_q;
  assign bin_bad_c   = accept_c && (dp_res_bin_i != bin_q);
  assign tmo_hit_c   = (state_q == S_WAIT_RES) && !accept_c &&
                       (tmo_q == TW'(TIMEOUT - 1));
  assign last_elem_c = (bin_q == BW'(NUM_BINS - 1)) &&
                       (frame_q == FW'(NUM_FRAMES - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; abort overrides every transition.
  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:     if (start_i) state_d = S_FETCH;
        S_FETCH:    state_d = S_WAIT_RD;
        S_WAIT_RD:  state_d = S_ISSUE;
        S_ISSUE:    state_d = S_WAIT_RES;
        S_WAIT_RES: begin
          if (accept_c)       state_d = bin_bad_c ? S_IDLE : S_WRITE;
          else if (tmo_hit_c) state_d = S_IDLE;
        end
        S_WRITE:    state_d = last_elem_c ? S_DONE : S_FETCH;
        S_DONE:     state_d = S_IDLE;
        default:    state_d = S_IDLE;
      endcase
    end
  end

  // Output and datapath next values; strobes follow the state being entered.
  always_comb begin
    bin_d       = bin_q;
    frame_d     = frame_q;
    addr_d      = addr_q;
    tmo_d       = tmo_q;
    err_d       = err_q;
    dp_data_d   = dp_data_q;
    dp_bin_d    = dp_bin_q;
    res_data_d  = res_data_q;
    res_addr_d  = res_addr_q;
    fb_addr_d   = fb_addr_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    fb_rd_en_d  = 1'b0;
    dp_req_d    = 1'b0;
    res_wr_en_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_ok_c) begin
          bin_d   = '0;
          frame_d = '0;
          addr_d  = '0;
          err_d   = 1'b0;
        end
      end
      S_WAIT_RD: dp_data_d = fb_rd_data_i;
      S_ISSUE:   tmo_d = '0;
      S_WAIT_RES: begin
        if (!abort_i) begin
          if (accept_c) begin
            res_data_d = dp_res_data_i;
            res_addr_d = addr_q;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
          if (bin_bad_c || tmo_hit_c) err_d = 1'b1;
        end
      end
      S_WRITE: begin
        if (!abort_i && !last_elem_c) begin
          addr_d = addr_q + AW'(1);
          if (bin_q == BW'(NUM_BINS - 1)) begin
            bin_d   = '0;
            frame_d = frame_q + FW'(1);
          end else begin
            bin_d = bin_q + BW'(1);
          end
        end
      end
      default: ;
    endcase

    if (state_d == S_FETCH) fb_addr_d = addr_d;
    if (state_d == S_ISSUE) dp_bin_d  = bin_q;

    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    fb_rd_en_d  = (state_d == S_FETCH);
    dp_req_d    = (state_d == S_ISSUE);
    res_wr_en_d = (state_d == S_WRITE);
  end

  // Counters, captured data and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q       <= '0;
      frame_q     <= '0;
      addr_q      <= '0;
      tmo_q       <= '0;
      err_q       <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fb_rd_en_q  <= 1'b0;
      fb_addr_q   <= '0;
      dp_req_q    <= 1'b0;
      dp_data_q   <= '0;
      dp_bin_q    <= '0;
      res_wr_en_q <= 1'b0;
      res_addr_q  <= '0;
      res_data_q  <= '0;
    end else begin
      bin_q       <= bin_d;
      frame_q     <= frame_d;
      addr_q      <= addr_d;
      tmo_q       <= tmo_d;
      err_q       <= err_d;
      valid_q     <= dp_res_valid_i;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fb_rd_en_q  <= fb_rd_en_d;
      fb_addr_q   <= fb_addr_d;
      dp_req_q    <= dp_req_d;
      dp_data_q   <= dp_data_d;
      dp_bin_q    <= dp_bin_d;
      res_wr_en_q <= res_wr_en_d;
      res_addr_q  <= res_addr_d;
      res_data_q  <= res_data_d;
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign fb_rd_en_o    = fb_rd_en_q;
  assign fb_rd_addr_o  = fb_addr_q;
  assign dp_req_o      = dp_req_q;
  assign dp_data_o     = dp_data_q;
  assign dp_bin_o      = dp_bin_q;
  assign res_wr_en_o   = res_wr_en_q;
  assign res_wr_addr_o = res_addr_q;
  assign res_wr_data_o = res_data_q;

endmodule

// File: tb/tb_cmvn_frame_sequencer.sv
// Bench for cmvn_frame_sequencer: feature buffer and CMVN datapath models,
// an expected-write queue filled per run and a monitor that drains it.
module tb_cmvn_frame_sequencer;

  localparam int unsigned NB = 20;
  localparam int unsigned NF = 50;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 10;
  localparam int unsigned TO = 16;
  localparam int unsigned NE = NB * NF;
  localparam logic [DW-1:0] K = 32'h0100_0000;

  localparam int M_PULSE  = 0;
  localparam int M_HOLD   = 1;
  localparam int M_SILENT = 2;
  localparam int M_WRONG  = 3;

  logic          clk, rst_n, start, abort;
  logic          busy, done, err, fb_rd_en, dp_req, res_wr_en;
  logic [AW-1:0] fb_rd_addr, res_wr_addr;
  logic [DW-1:0] fb_rd_data, dp_data, dp_res_data, res_wr_data;
  logic [4:0]    dp_bin, dp_res_bin;
  logic          dp_res_valid;

  cmvn_frame_sequencer #(
    .NUM_BINS(NB), .NUM_FRAMES(NF), .DW(DW), .AW(AW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort),
    .busy_o(busy), .done_o(done), .err_o(err),
    .fb_rd_en_o(fb_rd_en), .fb_rd_addr_o(fb_rd_addr), .fb_rd_data_i(fb_rd_data),
    .dp_req_o(dp_req), .dp_data_o(dp_data), .dp_bin_o(dp_bin),
    .dp_res_valid_i(dp_res_valid), .dp_res_bin_i(dp_res_bin), .dp_res_data_i(dp_res_data),
    .res_wr_en_o(res_wr_en), .res_wr_addr_o(res_wr_addr), .res_wr_data_o(res_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           exp_q[$];
  logic [DW-1:0] feat [NE];
  int            checks = 0;
  int            failures = 0;
  int            done_cnt = 0;
  int            mode = M_PULSE;
  int            lat_min = 3;
  int            lat_max = 3;
  int            fault_idx = -1;

  task automatic check(input bit ok, input string name, input logic [63:0] act,
                       input logic [63:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: datapath adds a fixed offset plus the bin index to the raw feature.
  function automatic logic [DW-1:0] exp_data(input int a);
    return feat[a] + K + DW'(a % NB);
  endfunction

  task automatic push_range(input int lo, input int hi);
    wr_t e;
    for (int a = lo; a <= hi; a++) begin
      e.addr = AW'(a);
      e.data = exp_data(a);
      exp_q.push_back(e);
    end
  endtask

  // Feature buffer: one-cycle read latency.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) fb_rd_data <= '0;
    else if (fb_rd_en) fb_rd_data <= (int'(fb_rd_addr) < NE) ? feat[fb_rd_addr] : '1;
  end

  // CMVN datapath model with configurable latency and fault injection.
  logic          pend;
  int            cnt;
  int            req_idx;
  logic [DW-1:0] pdata;
  logic [4:0]    pbin;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_res_valid <= 1'b0;
      dp_res_bin   <= '0;
      dp_res_data  <= '0;
      pend         <= 1'b0;
      cnt          <= 0;
      req_idx      <= 0;
      pdata        <= '0;
      pbin         <= '0;
    end else begin
      if (start && !busy) req_idx <= 0;
      if (dp_req) begin
        req_idx <= req_idx + 1;
        if (mode == M_HOLD) dp_res_valid <= 1'b0;
        if (!(mode == M_SILENT && req_idx == fault_idx)) begin
          pend  <= 1'b1;
          cnt   <= int'($urandom_range(lat_max, lat_min));
          pdata <= dp_data + K + DW'(dp_bin);
          pbin  <= (mode == M_WRONG && req_idx == fault_idx) ? dp_bin - 5'd1 : dp_bin;
        end
      end else if (pend) begin
        if (cnt <= 1) begin
          dp_res_valid <= 1'b1;
          dp_res_data  <= pdata;
          dp_res_bin   <= pbin;
          pend         <= 1'b0;
        end else begin
          cnt <= cnt - 1;
        end
      end else if (mode != M_HOLD) begin
        dp_res_valid <= 1'b0;
      end
    end
  end

  // Monitor: drain expected writes, track done pulses and outstanding requests.
  wr_t m_e;
  bit  outstanding = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (!busy) outstanding = 1'b0;
      if (res_wr_en) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_write", 64'(res_wr_addr), 64'hFFFF);
        end else begin
          m_e = exp_q.pop_front();
          check(res_wr_addr == m_e.addr && res_wr_data == m_e.data, "write",
                {22'd0, res_wr_addr, res_wr_data}, {22'd0, m_e.addr, m_e.data});
        end
        outstanding = 1'b0;
      end
      if (done) begin
        done_cnt++;
        check(exp_q.size() == 0, "done_after_last_write", 64'(exp_q.size()), 64'd0);
      end
      if (dp_req) begin
        check(!outstanding, "single_outstanding_req", 64'(outstanding), 64'd0);
        outstanding = 1'b1;
      end
    end
  end

  task automatic check_zero(input string name);
    check({busy, done, err, fb_rd_en, dp_req, res_wr_en, dp_bin, fb_rd_addr, res_wr_addr} == '0,
          {name, "_ctrl"},
          64'({busy, done, err, fb_rd_en, dp_req, res_wr_en, dp_bin, fb_rd_addr, res_wr_addr}),
          64'd0);
    check({dp_data, res_wr_data} == '0, {name, "_data"}, {dp_data, res_wr_data}, 64'd0);
  endtask

  task automatic do_start(input string name);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check(busy == 1'b1 && err == 1'b0, name, {62'd0, busy, err}, 64'd2);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check(!busy, name, 64'(busy), 64'd0);
  endtask

  task automatic wait_req(input int idx);
    int n = 0;
    while (!(dp_req && req_idx == idx) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check(dp_req && req_idx == idx, "reach_req", 64'(req_idx), 64'(idx));
  endtask

  task automatic fill_feat(input bit linear);
    for (int a = 0; a < int'(NE); a++) feat[a] = linear ? DW'(a) : DW'($urandom());
  endtask

  task automatic end_of_run(input string name, input bit err_exp, input int done_exp,
                            input int done0);
    check(exp_q.size() == 0, {name, "_all_written"}, 64'(exp_q.size()), 64'd0);
    check(err == err_exp, {name, "_err"}, 64'(err), 64'(err_exp));
    check(done_cnt - done0 == done_exp, {name, "_done_count"}, 64'(done_cnt - done0),
          64'(done_exp));
  endtask

  initial begin
    int d0;
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    fill_feat(1'b1);
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // start together with abort in IDLE stays IDLE
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check(!busy, "start_with_abort", 64'(busy), 64'd0);

    // clean run, features = address, latency 3; a start mid-run is ignored
    d0 = done_cnt;
    push_range(0, int'(NE) - 1);
    do_start("run1_start");
    repeat (100) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_idle("run1_idle");
    end_of_run("run1", 1'b0, 1, d0);

    // datapath holds valid high between results
    fill_feat(1'b0);
    mode = M_HOLD; lat_min = 1; lat_max = 4;
    d0 = done_cnt;
    push_range(0, int'(NE) - 1);
    do_start("run2_start");
    wait_idle("run2_idle");
    end_of_run("run2", 1'b0, 1, d0);

    // no response for bin 7 of frame 0: timeout
    mode = M_SILENT; fault_idx = 7; lat_min = 3; lat_max = 3;
    d0 = done_cnt;
    push_range(0, 6);
    do_start("run3_start");
    wait_req(7);
    n = 0;
    while (!err && n < 40) begin
      @(negedge clk);
      n++;
    end
    // TIMEOUT waiting cycles, then the registered flag appears
    check(n == int'(TO) + 1, "timeout_cycles", 64'(n), 64'(TO + 1));
    check(!busy, "timeout_busy_low", 64'(busy), 64'd0);
    repeat (5) @(negedge clk);
    end_of_run("run3", 1'b1, 0, d0);

    // wrong bin echoed for bin 4
    mode = M_WRONG; fault_idx = 4;
    d0 = done_cnt;
    push_range(0, 3);
    do_start("run4_start");
    wait_idle("run4_idle");
    repeat (5) @(negedge clk);
    end_of_run("run4", 1'b1, 0, d0);

    // abort while waiting for the result of frame 10, bin 3
    mode = M_PULSE; fault_idx = -1; lat_min = 3; lat_max = 3;
    d0 = done_cnt;
    push_range(0, 10 * int'(NB) + 2);
    do_start("run5_start");
    wait_req(10 * int'(NB) + 3);
    @(negedge clk) abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    check(!busy, "abort_idle", 64'(busy), 64'd0);
    repeat (20) @(negedge clk);
    end_of_run("run5", 1'b0, 0, d0);

    // restart after abort begins at address 0
    lat_min = 1; lat_max = 6;
    fill_feat(1'b0);
    d0 = done_cnt;
    push_range(0, int'(NE) - 1);
    do_start("run6_start");
    wait_idle("run6_idle");
    end_of_run("run6", 1'b0, 1, d0);

    // asynchronous reset during a write
    d0 = done_cnt;
    push_range(0, 55);
    do_start("run7_start");
    n = 0;
    while (!(res_wr_en && res_wr_addr == AW'(55)) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check(res_wr_en && res_wr_addr == AW'(55), "reach_write_55", 64'(res_wr_addr), 64'd55);
    #2 rst_n = 1'b0;
    #1 check_zero("reset_mid_run");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    end_of_run("run7", 1'b0, 0, d0);

    // clean run after reset release
    d0 = done_cnt;
    push_range(0, int'(NE) - 1);
    do_start("run8_start");
    wait_idle("run8_idle");
    repeat (3) @(negedge clk);
    end_of_run("run8", 1'b0, 1, d0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
